// File: rtl/priority_encoder_seq.sv
// priority_encoder_seq
// Captures a multi-hot request vector and replays the index of every set bit,
// one per valid/ready beat, in highest-first or lowest-first order. An
// all-zero vector yields a single beat flagged with Zero instead of code 0.

module priority_encoder_seq #(
  parameter int WIDTH      = 8,
  parameter bit HIGH_FIRST = 1'b1,
  localparam int CODE_W    = $clog2(WIDTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [WIDTH-1:0]  Data,
  input  logic              Load,
  output logic              In_ready,
  output logic [CODE_W-1:0] Code,
  output logic              Code_valid,
  input  logic              Code_ready,
  output logic              Last,
  output logic              Zero,
  output logic [CODE_W:0]   Count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [WIDTH-1:0]  pending_reg, pending_next;
  logic [CODE_W:0]   count_reg, count_next;

  logic [CODE_W-1:0] code_raw;
  logic [WIDTH-1:0]  emit_mask;
  logic              last_raw;
  logic              zero_raw;
  logic [CODE_W:0]   data_popcount;
  logic              in_scan;
  logic              beat_done;

  assign in_scan   = (state_reg == SCAN);
  assign beat_done = in_scan && Code_ready;

  // Select the priority bit of the pending vector and a one-hot mask that clears it.
  // The scan order makes the last match win, so the loop direction sets priority.
  always_comb begin
    code_raw  = '0;
    emit_mask = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_reg[i]) begin
          code_raw     = CODE_W'(i);
          emit_mask    = '0;
          emit_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_reg[i]) begin
          code_raw     = CODE_W'(i);
          emit_mask    = '0;
          emit_mask[i] = 1'b1;
        end
      end
    end
  end

  // At most one bit left means this beat finishes the vector (covers the all-zero case too).
  assign last_raw = ((pending_reg & (pending_reg - WIDTH'(1))) == '0);
  assign zero_raw = (pending_reg == '0);

  // Population count of the incoming vector, latched at capture time.
  always_comb begin
    data_popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      data_popcount = data_popcount + (CODE_W + 1)'(Data[i]);
    end
  end

  // Next-state: capture in IDLE, retire one bit per handshake in SCAN.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    count_next   = count_reg;
    if (state_reg == IDLE) begin
      if (Load) begin
        pending_next = Data;
        count_next   = data_popcount;
        state_next   = SCAN;
      end
    end else if (beat_done) begin
      pending_next = pending_reg & ~emit_mask;
      if (last_raw) begin
        state_next = IDLE;
      end
    end
  end

  // State registers with synchronous reset that also discards any scan in progress.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  // Beat outputs are forced to zero outside SCAN so IDLE never shows stale data.
  assign In_ready   = ~in_scan;
  assign Code_valid = in_scan;
  assign Code       = in_scan ? code_raw : '0;
  assign Last       = in_scan & last_raw;
  assign Zero       = in_scan & zero_raw;
  assign Count      = count_reg;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Scoreboard bench for priority_encoder_seq: stimulus pushes hand-computed
// beats into per-instance queues, monitors pop and compare on each handshake.

module tb_priority_encoder_seq;

  localparam int WIDTH  = 8;
  localparam int CODE_W = 3;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              last;
    logic              zero;
    logic [CODE_W:0]   count;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [WIDTH-1:0]  data;
  logic              load, load_lo;
  logic              code_ready;

  logic              in_ready, code_valid, last, zero;
  logic [CODE_W-1:0] code;
  logic [CODE_W:0]   count;

  logic              in_ready_lo, code_valid_lo, last_lo, zero_lo;
  logic [CODE_W-1:0] code_lo;
  logic [CODE_W:0]   count_lo;

  beat_t q_hi[$];
  beat_t q_lo[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_encoder_seq #(.WIDTH(WIDTH), .HIGH_FIRST(1'b1)) dut (
    .Clk(clk), .Rst(rst), .Data(data), .Load(load), .In_ready(in_ready),
    .Code(code), .Code_valid(code_valid), .Code_ready(code_ready),
    .Last(last), .Zero(zero), .Count(count)
  );

  priority_encoder_seq #(.WIDTH(WIDTH), .HIGH_FIRST(1'b0)) dut_lo (
    .Clk(clk), .Rst(rst), .Data(data), .Load(load_lo), .In_ready(in_ready_lo),
    .Code(code_lo), .Code_valid(code_valid_lo), .Code_ready(code_ready),
    .Last(last_lo), .Zero(zero_lo), .Count(count_lo)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the highest-first instance: compare every handshake and
  // check that a stalled beat is held unchanged into the next cycle.
  beat_t held_hi;
  logic  held_valid_hi = 1'b0;
  always @(negedge clk) begin
    beat_t got, exp;
    got = '{code: code, last: last, zero: zero, count: count};
    if (held_valid_hi && code_valid && !rst) begin
      check("hold_hi", int'(got), int'(held_hi));
    end
    held_valid_hi = code_valid && !code_ready && !rst;
    held_hi = got;
    if (code_valid && code_ready && !rst) begin
      if (q_hi.size() == 0) begin
        check("unexpected_beat_hi", int'(got), -1);
      end else begin
        exp = q_hi.pop_front();
        check("beat_hi", int'(got), int'(exp));
        $display("beat hi: code=%0d last=%0d zero=%0d count=%0d (exp code=%0d last=%0d zero=%0d count=%0d)",
                 got.code, got.last, got.zero, got.count, exp.code, exp.last, exp.zero, exp.count);
      end
    end
  end

  // Monitor for the lowest-first instance.
  always @(negedge clk) begin
    beat_t got, exp;
    got = '{code: code_lo, last: last_lo, zero: zero_lo, count: count_lo};
    if (code_valid_lo && code_ready && !rst) begin
      if (q_lo.size() == 0) begin
        check("unexpected_beat_lo", int'(got), -1);
      end else begin
        exp = q_lo.pop_front();
        check("beat_lo", int'(got), int'(exp));
        $display("beat lo: code=%0d last=%0d zero=%0d count=%0d (exp code=%0d last=%0d zero=%0d count=%0d)",
                 got.code, got.last, got.zero, got.count, exp.code, exp.last, exp.zero, exp.count);
      end
    end
  end

  function automatic beat_t mk(input int c, input int l, input int z, input int n);
    beat_t b;
    b.code  = CODE_W'(c);
    b.last  = 1'(l);
    b.zero  = 1'(z);
    b.count = (CODE_W + 1)'(n);
    return b;
  endfunction

  // Called at posedge+1; issues a one-cycle Load and returns in the first beat cycle.
  task automatic load_vec(input logic [WIDTH-1:0] d, input bit also_lo);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_load", int'(in_ready), 1);
    data    = d;
    load    = 1'b1;
    load_lo = also_lo;
    @(posedge clk); #1;
    load    = 1'b0;
    load_lo = 1'b0;
    check("valid_after_capture", int'(code_valid), 1);
    check("in_ready_low_in_scan", int'(in_ready), 0);
  endtask

  // Wait until both scoreboards are drained; the final handshake edge has then passed.
  task automatic wait_drain();
    int n = 0;
    while ((q_hi.size() != 0 || q_lo.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("drain_timeout", q_hi.size() + q_lo.size(), 0);
    check("in_ready_after_last", int'(in_ready), 1);
    check("valid_low_after_last", int'(code_valid), 0);
  endtask

  initial begin
    rst = 1'b1; data = '0; load = 1'b0; load_lo = 1'b0; code_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_code_valid", int'(code_valid), 0);
    check("rst_code", int'(code), 0);
    check("rst_last", int'(last), 0);
    check("rst_zero", int'(zero), 0);
    check("rst_count", int'(count), 0);
    @(posedge clk); #1;

    // Two-bit vector on both priority orders.
    code_ready = 1'b1;
    q_hi.push_back(mk(7, 0, 0, 2)); q_hi.push_back(mk(0, 1, 0, 2));
    q_lo.push_back(mk(0, 0, 0, 2)); q_lo.push_back(mk(7, 1, 0, 2));
    load_vec(8'b1000_0001, 1'b1);
    wait_drain();

    // All-zero vector: single flagged beat.
    q_hi.push_back(mk(0, 1, 1, 0));
    load_vec(8'b0000_0000, 1'b0);
    wait_drain();
    check("count_zero_held", int'(count), 0);

    // One-hot walk.
    for (int i = 0; i < WIDTH; i++) begin
      q_hi.push_back(mk(i, 1, 0, 1));
      load_vec(WIDTH'(1) << i, 1'b0);
      wait_drain();
    end

    // Back-pressure plus an ignored Load during SCAN.
    code_ready = 1'b0;
    q_hi.push_back(mk(6, 0, 0, 3)); q_hi.push_back(mk(4, 0, 0, 3)); q_hi.push_back(mk(2, 1, 0, 3));
    load_vec(8'b0101_0100, 1'b0);
    data = 8'hFF; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("bp_code_held", int'(code), 6);
    check("bp_count_held", int'(count), 3);
    code_ready = 1'b1;
    wait_drain();
    check("count_after_bp", int'(count), 3);

    // Reset in the middle of a scan discards the remaining beats.
    q_hi.push_back(mk(7, 0, 0, 4));
    load_vec(8'b1111_0000, 1'b0);
    @(posedge clk); #1;
    code_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_code_valid", int'(code_valid), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_queue", q_hi.size(), 0);
    @(posedge clk); #1;
    code_ready = 1'b1;
    q_hi.push_back(mk(1, 1, 0, 1));
    load_vec(8'b0000_0010, 1'b0);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
